m68k_bus_initiator: RTL and testbench
=====================================

Name: m68k_bus_initiator

Overview:
- 68000-compatible asynchronous bus-cycle initiator.
- It is the requester side of the AS/UDS/LDS/RW/DTACK handshake that the FC1004 answers. It stands in for the main CPU in test benches and headless configurations.
- It converts a single-word request on a simple host port into a correctly sequenced S0–S7 bus cycle, with wait states until DTACK and a timeout abort.

Parameters:
- TIMEOUT, 128, number of wait half-cycles tolerated in S4 before aborting with berr (range 2..1023).

Ports:
- MCLK  in  1  master clock; the only clock.
- RESET  in  1  reset, asynchronous, active-high.
- PH_e  in  1  one-MCLK pulse marking each CPU half-clock boundary; all state advances are qualified by it.
- bus_en  in  1  1 = bus owned by this initiator; a new cycle may start only when it is high.
- req  in  1  host request, level, sampled in IDLE.
- req_rw  in  1  1 = read, 0 = write.
- req_addr  in  23  word address, driven onto VA[23:1].
- req_be  in  2  byte enables, {upper, lower}; 2'b00 is illegal and is ignored.
- req_wdata  in  16  write data.
- ack  out  1  one-MCLK pulse when the cycle completes, normal or aborted.
- berr  out  1  valid with ack: 1 = timed out.
- rdata  out  16  read data, valid from ack until the next ack.
- busy  out  1  high from cycle start until ack.
- AS_o, UDS_o, LDS_o  out  1 each  active-low strobes.
- RW_o  out  1  1 = read.
- strobe_dir  out  1  1 = strobes/RW undriven (input), 0 = driven.
- VA_o  out  23  address.
- VA_d  out  1  1 = address undriven.
- VD_o  out  16  write data.
- VD_d  out  1  1 = data undriven (input).
- VD_i  in  16  data bus input.
- DTACK_i  in  1  active-low acknowledge, already synchronised.

Behaviour:
- Reset values: AS_o = UDS_o = LDS_o = RW_o = 1, strobe_dir = VA_d = VD_d = 1, VA_o = 0, VD_o = 0, ack = 0, berr = 0, busy = 0, rdata = 0, state = IDLE.
- All register updates happen on MCLK rising edges. State transitions occur only when PH_e = 1, except IDLE→S0, which needs PH_e as well.
- IDLE: if req & bus_en & req_be != 0 on a PH_e cycle:
  - latch addr/rw/be/wdata;
  - busy = 1;
  - go to S0.
- S0: strobe_dir = 0, RW_o = latched rw, VA_d stays 1.
- S1: VA_d = 0, VA_o = latched addr.
- S2:
  - AS_o = 0.
  - Read: UDS_o = ~be[1], LDS_o = ~be[0].
  - Write: data strobes stay high.
- S3 (write only): VD_d = 0, VD_o = wdata. Reads keep VD_d = 1 throughout.
- S4:
  - Write: assert data strobes on entry.
  - On each PH_e in S4, sample DTACK_i.
  - DTACK_i = 0 → go to S5.
  - DTACK_i = 1 → stay in S4 and increment the wait counter. Each two stalled PH_e count as one 68k wait state.
  - Wait counter reaches TIMEOUT → go to ABORT.
- S5: no output change.
- S6: read: rdata <= VD_i on the PH_e that leaves S6.
- S7:
  - AS_o = UDS_o = LDS_o = 1.
  - Leaving S7: VD_d = 1, VA_d = 1, strobe_dir = 1, RW_o = 1.
  - ack = 1, berr = 0, busy = 0, go to IDLE.
- ABORT, one PH_e:
  - All strobes high; all drivers undriven.
  - ack = 1, berr = 1; rdata unchanged; go to IDLE.
- Minimum cycle time is 8 PH_e (4 CPU clocks) from S0 to ack. Each stalled PH_e in S4 adds one.
- ack is a single-MCLK pulse coincident with busy falling. req may remain high; a new cycle cannot start before the next PH_e after ack.
- bus_en falling mid-cycle has no effect. The cycle completes or times out.
- req_be = 0: the request is never accepted and ack is never returned.
- RESET mid-cycle: all outputs return to reset values immediately (asynchronous). No ack is issued.
- The wait counter is 10 bits, cleared on S0 entry, and saturates with no wrap.

Decomposition:
- Shared package holds:
  - state enum (IDLE, S0..S7, ABORT);
  - strobe-inactive constant;
  - TIMEOUT width constant (10).
- One sub-module is natural: m68k_bus_wait_timer, holding the wait counter, clear, increment and timeout compare.

Test Plan:
- Read, be = 2'b11, addr 0x400000, DTACK low from S2, VD_i = 0xA55A -> ack 8 PH_e after S0; rdata = 0xA55A; berr = 0; UDS_o/LDS_o low S2–S6.
- Write, be = 2'b01, wdata 0x1234, DTACK delayed 6 PH_e -> LDS_o low from S4 while UDS_o stays high; VD_d = 0 S3–S7; ack after 14 PH_e.
- TIMEOUT = 4, DTACK never asserted -> ABORT after 4 stalled PH_e; ack & berr = 1; all strobes high; strobe_dir = VA_d = VD_d = 1.
- RESET pulse while in S4 of a write -> same MCLK: AS_o = UDS_o = LDS_o = 1, all _d = 1; no ack; next request after reset runs normally.
- bus_en = 0 with req = 1 for 20 PH_e -> busy stays 0, all drivers undriven; bus_en rising -> cycle starts on the next PH_e.
- Back-to-back reads with req held high -> exactly one PH_e of IDLE between ack and the next S0; rdata updates only at each ack.

Source files
------------

// File: rtl/m68k_bus_initiator_pkg.sv
// Shared types and constants for the 68000-style bus-cycle initiator.
package m68k_bus_initiator_pkg;

  localparam int unsigned ADDR_W = 23;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned WAIT_W = 10;

  localparam logic STROBE_OFF = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_S0,
    ST_S1,
    ST_S2,
    ST_S3,
    ST_S4,
    ST_S5,
    ST_S6,
    ST_S7,
    ST_ABORT
  } state_e;

  typedef struct packed {
    logic              rw;
    logic [1:0]        be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/m68k_bus_wait_timer.sv
// S4 wait-state counter: cleared at cycle start, saturating increment,
// last_o flags that the next stalled half-cycle reaches TIMEOUT.
module m68k_bus_wait_timer
  import m68k_bus_initiator_pkg::*;
#(
  parameter int unsigned TIMEOUT = 128
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic last_o
);

  localparam logic [WAIT_W-1:0] LIMIT_M1  = WAIT_W'(TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] COUNT_MAX = {WAIT_W{1'b1}};

  logic [WAIT_W-1:0] count_q, count_d;
  logic              last_q, last_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != COUNT_MAX)) begin
      count_d = count_q + WAIT_W'(1);
    end
    last_d = (count_d >= LIMIT_M1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
      last_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      last_q  <= last_d;
    end
  end

  assign last_o = last_q;

endmodule

// File: rtl/m68k_bus_initiator.sv
// Requester side of the AS/UDS/LDS/RW/DTACK handshake: turns one host word
// request into an S0..S7 bus cycle with DTACK wait states and timeout abort.
module m68k_bus_initiator
  import m68k_bus_initiator_pkg::*;
#(
  parameter int unsigned TIMEOUT = 128
) (
  input  logic              MCLK,
  input  logic              RESET,
  input  logic              PH_e,
  input  logic              bus_en,
  input  logic              req,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_be,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              ack,
  output logic              berr,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              AS_o,
  output logic              UDS_o,
  output logic              LDS_o,
  output logic              RW_o,
  output logic              strobe_dir,
  output logic [ADDR_W-1:0] VA_o,
  output logic              VA_d,
  output logic [DATA_W-1:0] VD_o,
  output logic              VD_d,
  input  logic [DATA_W-1:0] VD_i,
  input  logic              DTACK_i
);

  state_e state_q;
  req_t   req_q;
  logic   start_c;
  logic   stall_c;
  logic   wait_last;

  assign start_c = PH_e && (state_q == ST_IDLE) && req && bus_en && (req_be != 2'b00);
  assign stall_c = PH_e && (state_q == ST_S4) && DTACK_i;

  m68k_bus_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .clk_i (MCLK),
    .rst_i (RESET),
    .clr_i (start_c),
    .inc_i (stall_c),
    .last_o(wait_last)
  );

  // Outputs change on the PH_e edge that enters (or leaves) the named state.
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      req_q      <= '0;
      ack        <= 1'b0;
      berr       <= 1'b0;
      rdata      <= '0;
      busy       <= 1'b0;
      AS_o       <= STROBE_OFF;
      UDS_o      <= STROBE_OFF;
      LDS_o      <= STROBE_OFF;
      RW_o       <= 1'b1;
      strobe_dir <= 1'b1;
      VA_o       <= '0;
      VA_d       <= 1'b1;
      VD_o       <= '0;
      VD_d       <= 1'b1;
    end else begin
      ack <= 1'b0;
      if (PH_e) begin
        case (state_q)
          ST_IDLE: begin
            if (start_c) begin
              req_q      <= '{rw: req_rw, be: req_be, addr: req_addr, wdata: req_wdata};
              busy       <= 1'b1;
              strobe_dir <= 1'b0;
              RW_o       <= req_rw;
              state_q    <= ST_S0;
            end
          end
          ST_S0: begin
            VA_d    <= 1'b0;
            VA_o    <= req_q.addr;
            state_q <= ST_S1;
          end
          ST_S1: begin
            AS_o <= 1'b0;
            if (req_q.rw) begin
              UDS_o <= ~req_q.be[1];
              LDS_o <= ~req_q.be[0];
            end
            state_q <= ST_S2;
          end
          ST_S2: begin
            if (!req_q.rw) begin
              VD_d <= 1'b0;
              VD_o <= req_q.wdata;
            end
            state_q <= ST_S3;
          end
          ST_S3: begin
            if (!req_q.rw) begin
              UDS_o <= ~req_q.be[1];
              LDS_o <= ~req_q.be[0];
            end
            state_q <= ST_S4;
          end
          ST_S4: begin
            if (!DTACK_i) begin
              state_q <= ST_S5;
            end else if (wait_last) begin
              AS_o       <= STROBE_OFF;
              UDS_o      <= STROBE_OFF;
              LDS_o      <= STROBE_OFF;
              RW_o       <= 1'b1;
              strobe_dir <= 1'b1;
              VA_d       <= 1'b1;
              VD_d       <= 1'b1;
              state_q    <= ST_ABORT;
            end
          end
          ST_S5: begin
            state_q <= ST_S6;
          end
          ST_S6: begin
            if (req_q.rw) begin
              rdata <= VD_i;
            end
            AS_o    <= STROBE_OFF;
            UDS_o   <= STROBE_OFF;
            LDS_o   <= STROBE_OFF;
            state_q <= ST_S7;
          end
          ST_S7: begin
            VD_d       <= 1'b1;
            VA_d       <= 1'b1;
            strobe_dir <= 1'b1;
            RW_o       <= 1'b1;
            ack        <= 1'b1;
            berr       <= 1'b0;
            busy       <= 1'b0;
            state_q    <= ST_IDLE;
          end
          ST_ABORT: begin
            ack     <= 1'b1;
            berr    <= 1'b1;
            busy    <= 1'b0;
            state_q <= ST_IDLE;
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_m68k_bus_initiator.sv
// Directed bench for m68k_bus_initiator: default-timeout instance plus a
// TIMEOUT=4 instance with its own request and DTACK inputs.
module tb_m68k_bus_initiator;

  logic        MCLK = 1'b0;
  logic        RESET;
  logic        PH_e;
  logic        bus_en;
  logic        req;
  logic        req_to;
  logic        req_rw;
  logic [22:0] req_addr;
  logic [1:0]  req_be;
  logic [15:0] req_wdata;
  logic [15:0] VD_i;
  logic        DTACK_i;
  logic        DTACK_to;

  logic        ack, berr, busy, AS_o, UDS_o, LDS_o, RW_o, strobe_dir, VA_d, VD_d;
  logic [15:0] rdata, VD_o;
  logic [22:0] VA_o;

  logic        t_ack, t_berr, t_busy, t_AS, t_UDS, t_LDS, t_RW, t_strobe_dir, t_VA_d, t_VD_d;
  logic [15:0] t_rdata, t_VD_o;
  logic [22:0] t_VA_o;

  int n_assert = 0;
  int n_fail   = 0;

  m68k_bus_initiator u_dut (
    .MCLK(MCLK), .RESET(RESET), .PH_e(PH_e), .bus_en(bus_en), .req(req),
    .req_rw(req_rw), .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
    .ack(ack), .berr(berr), .rdata(rdata), .busy(busy),
    .AS_o(AS_o), .UDS_o(UDS_o), .LDS_o(LDS_o), .RW_o(RW_o), .strobe_dir(strobe_dir),
    .VA_o(VA_o), .VA_d(VA_d), .VD_o(VD_o), .VD_d(VD_d), .VD_i(VD_i), .DTACK_i(DTACK_i)
  );

  m68k_bus_initiator #(.TIMEOUT(4)) u_to (
    .MCLK(MCLK), .RESET(RESET), .PH_e(PH_e), .bus_en(bus_en), .req(req_to),
    .req_rw(req_rw), .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
    .ack(t_ack), .berr(t_berr), .rdata(t_rdata), .busy(t_busy),
    .AS_o(t_AS), .UDS_o(t_UDS), .LDS_o(t_LDS), .RW_o(t_RW), .strobe_dir(t_strobe_dir),
    .VA_o(t_VA_o), .VA_d(t_VA_d), .VD_o(t_VD_o), .VD_d(t_VD_d), .VD_i(VD_i), .DTACK_i(DTACK_to)
  );

  always #5 MCLK = ~MCLK;

  // PH_e is high across every second rising MCLK edge.
  initial begin
    PH_e = 1'b0;
    forever begin
      @(posedge MCLK);
      #1 PH_e = 1'b1;
      @(posedge MCLK);
      #1 PH_e = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next PH_e-qualified MCLK edge.
  task automatic ph_step();
    do @(posedge MCLK); while (PH_e !== 1'b1);
    #2;
  endtask

  task automatic wait_ack(input string tag, input int max_ph, input int exp_ph, input bit use_to);
    int  n;
    bit  got;
    n   = 0;
    got = 1'b0;
    while (!got && n < max_ph) begin
      ph_step();
      n++;
      got = use_to ? t_ack : ack;
    end
    chk(tag, 32'(n), 32'(exp_ph));
  endtask

  initial begin
    RESET     = 1'b1;
    bus_en    = 1'b1;
    req       = 1'b0;
    req_to    = 1'b0;
    req_rw    = 1'b1;
    req_addr  = '0;
    req_be    = 2'b11;
    req_wdata = '0;
    VD_i      = '0;
    DTACK_i   = 1'b1;
    DTACK_to  = 1'b1;
    repeat (3) @(posedge MCLK);
    #2 RESET = 1'b0;

    chk("reset_ctl", {AS_o, UDS_o, LDS_o, RW_o, strobe_dir, VA_d, VD_d, ack, berr, busy}, 10'b1111111000);
    chk("reset_bus", {VA_o, VD_o, rdata}, '0);
    ph_step();

    // Read, both bytes, DTACK already low.
    req = 1'b1; req_rw = 1'b1; req_be = 2'b11; req_addr = 23'h400000;
    VD_i = 16'hA55A; DTACK_i = 1'b0;
    ph_step();
    req = 1'b0;
    chk("rd_s0", {busy, strobe_dir, RW_o, VA_d, AS_o}, 5'b10111);
    for (int k = 1; k <= 8; k++) begin
      ph_step();
      if (k == 1) chk("rd_s1_addr", {VA_d, VA_o}, {1'b0, 23'h400000});
      if (k == 2) chk("rd_s2_strobes", {AS_o, UDS_o, LDS_o, VD_d}, 4'b0001);
      if (k == 6) chk("rd_s6_strobes", {AS_o, UDS_o, LDS_o}, 3'b000);
      if (k == 7) chk("rd_s7", {AS_o, UDS_o, LDS_o, ack, rdata}, {4'b1110, 16'hA55A});
      if (k == 8) chk("rd_ack", {ack, berr, busy, strobe_dir, VA_d, RW_o}, 6'b100111);
    end
    @(posedge MCLK); #2;
    chk("rd_ack_pulse", {ack, busy}, 2'b00);
    ph_step();

    // Write, lower byte only, DTACK held off for 6 stalled PH_e.
    req = 1'b1; req_rw = 1'b0; req_be = 2'b01; req_addr = 23'h012345;
    req_wdata = 16'h1234; DTACK_i = 1'b1;
    ph_step();
    req = 1'b0;
    chk("wr_s0_rw", {busy, RW_o}, 2'b10);
    for (int k = 1; k <= 14; k++) begin
      if (k == 11) DTACK_i = 1'b0;
      ph_step();
      if (k == 2)  chk("wr_s2", {AS_o, UDS_o, LDS_o, RW_o}, 4'b0110);
      if (k == 3)  chk("wr_s3_data", {VD_d, VD_o, UDS_o, LDS_o}, {1'b0, 16'h1234, 2'b11});
      if (k == 4)  chk("wr_s4_lds", {UDS_o, LDS_o}, 2'b10);
      if (k == 10) chk("wr_stall", {busy, LDS_o, ack}, 3'b100);
      if (k == 13) chk("wr_s7", {AS_o, UDS_o, LDS_o, VD_d, ack}, 5'b11100);
      if (k == 14) chk("wr_ack", {ack, berr, busy, VD_d, VA_d, strobe_dir, RW_o}, 7'b1001111);
    end
    chk("wr_rdata_kept", rdata, 16'hA55A);
    ph_step();

    // Back-to-back reads with req held high.
    req = 1'b1; req_rw = 1'b1; req_be = 2'b10; req_addr = 23'h000100;
    VD_i = 16'h1111; DTACK_i = 1'b0;
    ph_step();
    for (int k = 1; k <= 17; k++) begin
      ph_step();
      if (k == 2)  chk("b2b_s2_uds", {UDS_o, LDS_o}, 2'b01);
      if (k == 8) begin
        chk("b2b_ack1", {ack, busy, rdata}, {2'b10, 16'h1111});
        VD_i = 16'h2222;
      end
      if (k == 9) begin
        chk("b2b_restart", {busy, ack, strobe_dir}, 3'b100);
        req = 1'b0;
      end
      if (k == 12) chk("b2b_rdata_hold", rdata, 16'h1111);
      if (k == 16) chk("b2b_s7", ack, 1'b0);
      if (k == 17) chk("b2b_ack2", {ack, berr, rdata}, {2'b10, 16'h2222});
    end
    ph_step();

    // bus_en low blocks the request; dropping it mid-cycle does not.
    bus_en = 1'b0; req = 1'b1; req_rw = 1'b1; req_be = 2'b11;
    VD_i = 16'h5A5A; DTACK_i = 1'b0;
    for (int k = 0; k < 20; k++) begin
      ph_step();
      chk("busen_blocked", {busy, strobe_dir, VA_d, VD_d, AS_o}, 5'b01111);
    end
    bus_en = 1'b1;
    ph_step();
    chk("busen_start", {busy, strobe_dir}, 2'b10);
    bus_en = 1'b0; req = 1'b0;
    wait_ack("busen_latency", 20, 8, 1'b0);
    chk("busen_rdata", {berr, rdata}, {1'b0, 16'h5A5A});
    bus_en = 1'b1;
    ph_step();

    // Timeout instance (TIMEOUT=4), DTACK never asserted.
    req_to = 1'b1; req_rw = 1'b1; req_be = 2'b11; VD_i = 16'hCCCC; DTACK_to = 1'b1;
    ph_step();
    req_to = 1'b0;
    chk("to_s0", t_busy, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      ph_step();
      if (k == 7) chk("to_stall", {t_AS, t_busy, t_ack}, 3'b010);
      if (k == 8) chk("to_abort", {t_AS, t_UDS, t_LDS, t_strobe_dir, t_VA_d, t_VD_d, t_ack, t_busy},
                      8'b11111101);
    end
    ph_step();
    chk("to_ack", {t_ack, t_berr, t_busy, t_rdata}, {3'b110, 16'h0000});
    chk("to_idle_main", busy, 1'b0);
    @(posedge MCLK); #2;
    chk("to_ack_pulse", t_ack, 1'b0);
    ph_step();

    // Asynchronous reset in S4 of a write.
    req = 1'b1; req_rw = 1'b0; req_be = 2'b11; req_wdata = 16'h7777; DTACK_i = 1'b1;
    ph_step();
    req = 1'b0;
    repeat (5) ph_step();
    chk("rst_pre_s4", {AS_o, UDS_o, LDS_o, VD_d, busy}, 5'b00001);
    #1 RESET = 1'b1;
    #1;
    chk("rst_async_ctl", {AS_o, UDS_o, LDS_o, RW_o, strobe_dir, VA_d, VD_d, ack, berr, busy}, 10'b1111111000);
    chk("rst_async_bus", {VA_o, VD_o}, '0);
    repeat (2) ph_step();
    chk("rst_held_ack", ack, 1'b0);
    RESET = 1'b0;
    repeat (3) begin
      ph_step();
      chk("rst_no_ack", {ack, busy}, 2'b00);
    end

    // Normal read after reset.
    req = 1'b1; req_rw = 1'b1; req_be = 2'b11; VD_i = 16'hBEEF; DTACK_i = 1'b0;
    ph_step();
    req = 1'b0;
    chk("post_rst_start", busy, 1'b1);
    wait_ack("post_rst_latency", 20, 8, 1'b0);
    chk("post_rst_rdata", {berr, rdata}, {1'b0, 16'hBEEF});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
